// File: rtl/status_reg.sv
// CPU flag register: full-word load from the ALU or the decoder, plus per-bit
// set/clear strobes, with a registered "flags changed" indication.
module status_reg #(
    parameter int NUM_STATUS_BITS = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       wr_en,
    input  logic                       sel_stat_in_alu_decoder,
    input  logic [NUM_STATUS_BITS-1:0] alu_status,
    input  logic [NUM_STATUS_BITS-1:0] dec_status,
    input  logic [NUM_STATUS_BITS-1:0] set_bits,
    input  logic [NUM_STATUS_BITS-1:0] clr_bits,
    output logic [NUM_STATUS_BITS-1:0] status,
    output logic                       status_changed
);

    logic [NUM_STATUS_BITS-1:0] status_q;
    logic [NUM_STATUS_BITS-1:0] status_d;
    logic [NUM_STATUS_BITS-1:0] load_src;
    logic                       changed_q;
    logic                       changed_d;

    assign load_src = sel_stat_in_alu_decoder ? alu_status : dec_status;

    // A full-word write masks the strobes; among strobes, set beats clear.
    always_comb begin
        status_d = status_q;
        if (wr_en) begin
            status_d = load_src;
        end else begin
            status_d = set_bits | (status_q & ~clr_bits);
        end
        changed_d = (status_d != status_q);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            status_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            changed_q <= changed_d;
        end
    end

    assign status         = status_q;
    assign status_changed = changed_q;

endmodule

// File: tb/tb_status_reg.sv
// Directed bench for status_reg: reset, both load paths, hold, set/clear
// strobes, asynchronous reset mid-cycle and back-to-back writes.
module tb_status_reg;

    localparam int W = 4;

    logic         clk;
    logic         res;
    logic         wr_en;
    logic         sel;
    logic [W-1:0] alu_status;
    logic [W-1:0] dec_status;
    logic [W-1:0] set_bits;
    logic [W-1:0] clr_bits;
    logic [W-1:0] status;
    logic         status_changed;

    int checks = 0;
    int errors = 0;

    status_reg #(.NUM_STATUS_BITS(W)) dut (
        .clk                     (clk),
        .res                     (res),
        .wr_en                   (wr_en),
        .sel_stat_in_alu_decoder (sel),
        .alu_status              (alu_status),
        .dec_status              (dec_status),
        .set_bits                (set_bits),
        .clr_bits                (clr_bits),
        .status                  (status),
        .status_changed          (status_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample 1 time unit after the rising edge; inputs are driven there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1; wr_en = 1'b0; sel = 1'b0;
        alu_status = '0; dec_status = '0; set_bits = '0; clr_bits = '0;
        #3;
        checks++;
        if (status !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b expected %b", status, 4'b0000);
        end
        checks++;
        if (status_changed !== 1'b0) begin
            errors++; $display("FAIL reset_changed: got %b expected %b", status_changed, 1'b0);
        end
        tick();
        tick();
        res = 1'b0;
        tick();
        checks++;
        if (status !== 4'b0000 || status_changed !== 1'b0) begin
            errors++; $display("FAIL reset_release: got %b/%b expected 0000/0", status, status_changed);
        end
    endtask

    task automatic test_alu_path();
        wr_en = 1'b1; sel = 1'b1; alu_status = 4'b0001; dec_status = 4'b0011;
        #2;
        checks++;
        if (status !== 4'b0000) begin
            errors++; $display("FAIL alu_no_comb_path: got %b expected %b", status, 4'b0000);
        end
        tick();
        checks++;
        if (status !== 4'b0001 || status_changed !== 1'b1) begin
            errors++; $display("FAIL alu_load_0001: got %b/%b expected 0001/1", status, status_changed);
        end
        alu_status = 4'b0010;
        tick();
        checks++;
        if (status !== 4'b0010 || status_changed !== 1'b1) begin
            errors++; $display("FAIL alu_load_0010: got %b/%b expected 0010/1", status, status_changed);
        end
        alu_status = 4'b0000;
        tick();
        checks++;
        if (status !== 4'b0000 || status_changed !== 1'b1) begin
            errors++; $display("FAIL alu_load_0000: got %b/%b expected 0000/1", status, status_changed);
        end
    endtask

    task automatic test_hold();
        wr_en = 1'b0; sel = 1'b1; alu_status = 4'b0001; dec_status = 4'b1111;
        tick();
        tick();
        checks++;
        if (status !== 4'b0000 || status_changed !== 1'b0) begin
            errors++; $display("FAIL hold: got %b/%b expected 0000/0", status, status_changed);
        end
    endtask

    task automatic test_decoder_path();
        wr_en = 1'b1; sel = 1'b0; dec_status = 4'b0011; alu_status = 4'b1100;
        tick();
        checks++;
        if (status !== 4'b0011 || status_changed !== 1'b1) begin
            errors++; $display("FAIL dec_load_0011: got %b/%b expected 0011/1", status, status_changed);
        end
    endtask

    task automatic test_set_clear();
        wr_en = 1'b0; set_bits = 4'b1000; clr_bits = 4'b0001;
        tick();
        checks++;
        if (status !== 4'b1010 || status_changed !== 1'b1) begin
            errors++; $display("FAIL set_clr_1010: got %b/%b expected 1010/1", status, status_changed);
        end
        set_bits = 4'b0000; clr_bits = 4'b0000;
        tick();
        checks++;
        if (status !== 4'b1010 || status_changed !== 1'b0) begin
            errors++; $display("FAIL changed_one_cycle: got %b/%b expected 1010/0", status, status_changed);
        end
        set_bits = 4'b0100; clr_bits = 4'b0100;
        tick();
        checks++;
        if (status !== 4'b1110 || status_changed !== 1'b1) begin
            errors++; $display("FAIL set_wins: got %b/%b expected 1110/1", status, status_changed);
        end
        set_bits = 4'b0000; clr_bits = 4'b0110;
        tick();
        checks++;
        if (status !== 4'b1000 || status_changed !== 1'b1) begin
            errors++; $display("FAIL clear_bits: got %b/%b expected 1000/1", status, status_changed);
        end
        wr_en = 1'b1; sel = 1'b1; alu_status = 4'b0000; set_bits = 4'b1111; clr_bits = 4'b0000;
        tick();
        checks++;
        if (status !== 4'b0000 || status_changed !== 1'b1) begin
            errors++; $display("FAIL write_beats_set: got %b/%b expected 0000/1", status, status_changed);
        end
        set_bits = 4'b0000;
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1; sel = 1'b0; dec_status = 4'b0011;
        tick();
        checks++;
        if (status !== 4'b0011) begin
            errors++; $display("FAIL pre_reset_load: got %b expected %b", status, 4'b0011);
        end
        #2 res = 1'b1;
        #1;
        checks++;
        if (status !== 4'b0000 || status_changed !== 1'b0) begin
            errors++; $display("FAIL async_reset: got %b/%b expected 0000/0", status, status_changed);
        end
        tick();
        checks++;
        if (status !== 4'b0000) begin
            errors++; $display("FAIL reset_overrides_write: got %b expected %b", status, 4'b0000);
        end
        res = 1'b0;
        tick();
        checks++;
        if (status !== 4'b0011 || status_changed !== 1'b1) begin
            errors++; $display("FAIL post_reset_load: got %b/%b expected 0011/1", status, status_changed);
        end
        tick();
        checks++;
        if (status !== 4'b0011 || status_changed !== 1'b0) begin
            errors++; $display("FAIL equal_write_no_change: got %b/%b expected 0011/0", status, status_changed);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals [4];
        logic [W-1:0] prev;
        vals[0] = 4'b1001; vals[1] = 4'b0110; vals[2] = 4'b0110; vals[3] = 4'b1111;
        prev = 4'b0011;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            alu_status = sel ? vals[i] : ~vals[i];
            dec_status = sel ? ~vals[i] : vals[i];
            tick();
            checks++;
            if (status !== vals[i] || status_changed !== (vals[i] != prev)) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %b/%b expected %b/%b",
                         i, status, status_changed, vals[i], (vals[i] != prev));
            end
            prev = vals[i];
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_path();
        test_hold();
        test_decoder_path();
        test_set_clear();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
